// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
// Instruction-fetch front end of the single-cycle RISC core. Holds the program
// counter, computes PC+4, selects between PC+4 and a branch target, issues word
// fetches to instruction memory over a valid/ready handshake, and presents each
// fetched instruction with its PC to the downstream decode/datapath stage.
//
// Parameters:
//   XLEN      address/instruction width (only 32 is supported)
//   RESET_PC  word-aligned PC loaded on reset
//
// Ports:
//   clk            in   rising-edge clock
//   rst_n          in   asynchronous active-low reset
//   stall          in   hold PC and suppress new fetch requests
//   branch_taken   in   redirect request this cycle
//   branch_target  in   redirect address
//   imem_req       out  fetch request valid (combinational with stall)
//   imem_addr      out  fetch address (= PC)
//   imem_ready     in   memory accepts the request and returns data this cycle
//   imem_rdata     in   instruction word, valid on imem_req && imem_ready
//   instr          out  last accepted instruction
//   instr_pc       out  PC of instr
//   instr_valid    out  one-cycle pulse: new instr present
//   pc_plus4       out  PC+4, modulo 2^XLEN
//   misalign       out  sticky misaligned-target flag (PC_MISALIGN_TRAP_EN only)
//
// Optional feature macro: PC_MISALIGN_TRAP_EN
//   Defined: a branch to a non-word-aligned target leaves the PC untouched,
//   raises the sticky misalign flag and parks the unit in HALT until reset.
//   Undefined: no misalign port, no HALT state, target low bits are cleared.

module pc_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic            instr_valid,
    output logic [XLEN-1:0] pc_plus4
`ifdef PC_MISALIGN_TRAP_EN
    ,
    output logic            misalign
`endif
);

    localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

`ifdef PC_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;
`else
    typedef enum logic [0:0] {IDLE, FETCH} state_t;
`endif

    state_t          state, state_next;
    logic [XLEN-1:0] pc, pc_next;
    logic [XLEN-1:0] instr_next, instr_pc_next;
    logic            instr_valid_next;
    logic            handshake;
    logic            branch_load;
    logic [XLEN-1:0] target_aligned;
`ifdef PC_MISALIGN_TRAP_EN
    logic            branch_trap;
    logic            misalign_next;
`endif

    assign imem_addr      = pc;
    assign pc_plus4       = pc + XLEN'(4);
    assign imem_req       = (state == FETCH) && !stall;
    assign handshake      = imem_req && imem_ready;
    // Masking the whole vector keeps every target bit in use even though the
    // low two bits never reach the PC.
    assign target_aligned = branch_target & ~XLEN'(3);

`ifdef PC_MISALIGN_TRAP_EN
    assign branch_trap = branch_taken && (branch_target[1:0] != 2'b00);
    assign branch_load = branch_taken && !branch_trap;
`else
    assign branch_load = branch_taken;
`endif

    // State, PC and instruction registers; reset drops any in-flight word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instr       <= NOP;
            instr_pc    <= RESET_PC;
            instr_valid <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
            misalign    <= 1'b0;
`endif
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            instr       <= instr_next;
            instr_pc    <= instr_pc_next;
            instr_valid <= instr_valid_next;
`ifdef PC_MISALIGN_TRAP_EN
            misalign    <= misalign_next;
`endif
        end
    end

    // Next-state logic. A branch wins over both stall and a same-cycle
    // handshake; the word returned in that cycle is simply not captured.
    always_comb begin
        state_next       = state;
        pc_next          = pc;
        instr_next       = instr;
        instr_pc_next    = instr_pc;
        instr_valid_next = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
        misalign_next    = misalign;
`endif
        case (state)
            IDLE: begin
                state_next = FETCH;
                if (branch_load) begin
                    pc_next = target_aligned;
                end
`ifdef PC_MISALIGN_TRAP_EN
                if (branch_trap) begin
                    state_next    = HALT;
                    misalign_next = 1'b1;
                end
`endif
            end
            FETCH: begin
                if (branch_load) begin
                    pc_next = target_aligned;
`ifdef PC_MISALIGN_TRAP_EN
                end else if (branch_trap) begin
                    state_next    = HALT;
                    misalign_next = 1'b1;
`endif
                end else if (handshake) begin
                    instr_next       = imem_rdata;
                    instr_pc_next    = pc;
                    instr_valid_next = 1'b1;
                    pc_next          = pc_plus4;
                end
            end
            default: begin
                state_next = state;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit
// Self-checking bench for pc_fetch_unit: directed scenarios with literal
// expectations followed by randomized traffic, all checked every cycle
// against a behavioural model of the fetch front end.

module tb_pc_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic [31:0] pc_plus4;
`ifdef PC_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    int checks;
    int errors;

    // Behavioural model state: the PC, whether the post-reset idle cycle has
    // elapsed, whether a misaligned branch has halted the unit, and the
    // registered outputs the downstream stage would see.
    logic [31:0] m_pc;
    logic        m_started;
    logic        m_halted;
    logic        m_misalign;
    logic [31:0] m_instr;
    logic [31:0] m_instr_pc;
    logic        m_valid;

    pc_fetch_unit #(
        .XLEN    (32),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .instr_valid  (instr_valid),
        .pc_plus4     (pc_plus4)
`ifdef PC_MISALIGN_TRAP_EN
        ,
        .misalign     (misalign)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic compare(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic resetModel();
        m_pc       = 32'h0;
        m_started  = 1'b0;
        m_halted   = 1'b0;
        m_misalign = 1'b0;
        m_instr    = 32'h0000_0013;
        m_instr_pc = 32'h0;
        m_valid    = 1'b0;
    endtask

    // Apply one clock edge's worth of behaviour to the model from the inputs
    // that were present during the cycle.
    task automatic modelStep();
        logic branch_ok;
        branch_ok = 1'b1;
`ifdef PC_MISALIGN_TRAP_EN
        branch_ok = (branch_target % 4) == 0;
`endif
        if (m_halted) begin
            m_valid = 1'b0;
        end else if (branch_taken) begin
            m_valid   = 1'b0;
            m_started = 1'b1;
            if (branch_ok) begin
                m_pc = (branch_target / 4) * 4;
            end else begin
                m_halted   = 1'b1;
                m_misalign = 1'b1;
            end
        end else if (!m_started) begin
            m_started = 1'b1;
            m_valid   = 1'b0;
        end else if (!stall && imem_ready) begin
            m_instr    = imem_rdata;
            m_instr_pc = m_pc;
            m_valid    = 1'b1;
            m_pc       = m_pc + 32'd4;
        end else begin
            m_valid = 1'b0;
        end
    endtask

    // Per-cycle comparison of every DUT output against the model.
    task automatic checkOutput();
        logic exp_req;
        exp_req = m_started && !m_halted && !stall;
        compare("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
        compare("imem_addr", imem_addr, m_pc);
        compare("pc_plus4", pc_plus4, m_pc + 32'd4);
        compare("instr", instr, m_instr);
        compare("instr_pc", instr_pc, m_instr_pc);
        compare("instr_valid", {31'b0, instr_valid}, {31'b0, m_valid});
`ifdef PC_MISALIGN_TRAP_EN
        compare("misalign", {31'b0, misalign}, {31'b0, m_misalign});
`endif
    endtask

    // Drive inputs for the current cycle (called just after a falling edge)
    // and check outputs once they have settled.
    task automatic applyStimulus(input logic s, input logic b, input logic [31:0] t,
                                 input logic r, input logic [31:0] d);
        stall         = s;
        branch_taken  = b;
        branch_target = t;
        imem_ready    = r;
        imem_rdata    = d;
        #1;
        checkOutput();
    endtask

    task automatic tick();
        @(posedge clk);
        modelStep();
        @(negedge clk);
    endtask

    // Asynchronous reset pulse in the middle of a cycle; outputs must return
    // to reset values without waiting for a clock edge.
    task automatic pulseReset();
        #2;
        rst_n = 1'b0;
        #1;
        compare("rst_imem_req", {31'b0, imem_req}, 32'h0);
        compare("rst_instr_valid", {31'b0, instr_valid}, 32'h0);
        compare("rst_instr", instr, 32'h0000_0013);
        compare("rst_instr_pc", instr_pc, 32'h0);
        compare("rst_imem_addr", imem_addr, 32'h0);
`ifdef PC_MISALIGN_TRAP_EN
        compare("rst_misalign", {31'b0, misalign}, 32'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        resetModel();
    endtask

    initial begin
        logic [31:0] t;
        logic [31:0] held_pc;
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        imem_ready    = 1'b0;
        imem_rdata    = 32'h0;
        resetModel();
        repeat (3) @(negedge clk);
        compare("reset_instr", instr, 32'h0000_0013);
        compare("reset_valid", {31'b0, instr_valid}, 32'h0);
        rst_n = 1'b1;

        // Reset release with ready tied high: idle cycle, then 0, 4, 8, ...
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, $urandom);
        compare("first_cycle_req", {31'b0, imem_req}, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, $urandom);
        compare("first_req", {31'b0, imem_req}, 32'h1);
        compare("first_addr", imem_addr, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, $urandom);
        compare("second_addr", imem_addr, 32'h4);
        compare("cycle3_valid", {31'b0, instr_valid}, 32'h1);
        compare("cycle3_instr_pc", instr_pc, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, $urandom);
        compare("third_addr", imem_addr, 32'h8);
        compare("trail_instr_pc", instr_pc, 32'h4);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, $urandom);
        tick();

        // Ready low for three cycles at 0x10, then DEADBEEF is accepted.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, $urandom);
            compare("wait_addr", imem_addr, 32'h10);
            if (i > 0) compare("wait_valid", {31'b0, instr_valid}, 32'h0);
            tick();
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, $urandom);
        compare("beef_instr", instr, 32'hDEAD_BEEF);
        compare("beef_instr_pc", instr_pc, 32'h10);
        compare("beef_next_addr", imem_addr, 32'h14);
        tick();

        // Branch coinciding with a handshake at 0x40 discards the word.
        applyStimulus(1'b0, 1'b1, 32'h40, 1'b0, $urandom);
        tick();
        applyStimulus(1'b0, 1'b1, 32'h200, 1'b1, 32'h1234_5678);
        compare("br_hs_addr", imem_addr, 32'h40);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, $urandom);
        compare("br_hs_valid", {31'b0, instr_valid}, 32'h0);
        compare("br_hs_target", imem_addr, 32'h200);
        tick();

        // Stall for two cycles at 0x80, then stall together with a branch.
        applyStimulus(1'b0, 1'b1, 32'h80, 1'b0, $urandom);
        tick();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, $urandom);
            compare("stall_req", {31'b0, imem_req}, 32'h0);
            compare("stall_addr", imem_addr, 32'h80);
            tick();
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, $urandom);
        compare("unstall_req", {31'b0, imem_req}, 32'h1);
        compare("unstall_addr", imem_addr, 32'h80);
        tick();
        applyStimulus(1'b1, 1'b1, 32'h100, 1'b1, $urandom);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, $urandom);
        compare("stall_branch_addr", imem_addr, 32'h100);
        tick();

        // Wrap-around of the PC at the top of the address space.
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, $urandom);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, $urandom);
        compare("wrap_addr_hi", imem_addr, 32'hFFFF_FFFC);
        compare("wrap_plus4", pc_plus4, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, $urandom);
        compare("wrap_addr_lo", imem_addr, 32'h0);
        compare("wrap_instr_pc", instr_pc, 32'hFFFF_FFFC);
        tick();

        // Misaligned branch target 0x102.
        held_pc = 32'h0;
        applyStimulus(1'b0, 1'b1, 32'h102, 1'b0, $urandom);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, $urandom);
`ifdef PC_MISALIGN_TRAP_EN
        compare("trap_misalign", {31'b0, misalign}, 32'h1);
        compare("trap_req", {31'b0, imem_req}, 32'h0);
        compare("trap_addr", imem_addr, held_pc);
        tick();
        applyStimulus(1'b0, 1'b1, 32'h300, 1'b1, $urandom);
        compare("halt_req", {31'b0, imem_req}, 32'h0);
        tick();
`else
        compare("mask_addr", imem_addr, 32'h100);
        compare("mask_held_pc", {31'b0, imem_addr == held_pc}, 32'h0);
        tick();
`endif
        pulseReset();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, $urandom);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, $urandom);
        compare("restart_addr", imem_addr, 32'h0);
        tick();

        // Randomized traffic checked every cycle against the model.
        for (int i = 0; i < 600; i++) begin
            t = $urandom;
`ifdef PC_MISALIGN_TRAP_EN
            if ($urandom_range(0, 29) != 0) t[1:0] = 2'b00;
`endif
            applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0, t,
                          $urandom_range(0, 9) < 7, $urandom);
            tick();
            if (i == 250 || i == 450) pulseReset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
